cv32e40s_obi_txn_tracker: RTL and testbench

Address-phase and outstanding-transaction tracker between the MPU's bus-side port and the OBI data or instruction bus. It accepts transfers that passed MPU checks. It holds OBI address-phase signals stable while `gnt` is low, and counts transactions in flight up to `MAX_OUTSTANDING`. It also produces the next-cycle one-pending indication that the MPU error FSM consumes.

---
 rtl/cv32e40s_obi_txn_tracker.sv | 130 +++++++++++++
 tb/tb_cv32e40s_obi_txn_tracker.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_obi_txn_tracker.sv
// OBI address-phase holder and outstanding-transaction counter between the MPU and the OBI bus.
// Attributes pass through until an accepted request is not granted, then they are held stable.
module cv32e40s_obi_txn_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trans_valid_i,
  output logic             trans_ready_o,
  input  logic [31:0]      trans_addr_i,
  input  logic             trans_we_i,
  input  logic [3:0]       trans_be_i,
  input  logic [31:0]      trans_wdata_i,
  input  logic [2:0]       trans_prot_i,
  input  logic [1:0]       trans_memtype_i,
  output logic             obi_req_o,
  input  logic             obi_gnt_i,
  output logic [31:0]      obi_addr_o,
  output logic             obi_we_o,
  output logic [3:0]       obi_be_o,
  output logic [31:0]      obi_wdata_o,
  output logic [2:0]       obi_prot_o,
  output logic [1:0]       obi_memtype_o,
  input  logic             obi_rvalid_i,
  input  logic [31:0]      obi_rdata_i,
  input  logic             obi_err_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_rdata_o,
  output logic             resp_err_o,
  output logic [CNT_W-1:0] outstanding_cnt_o,
  output logic             one_txn_pend_n_o
);

  typedef enum logic {StTransparent, StRegistered} state_e;

  state_e           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             w_full, w_accept, w_latch;

  logic [31:0] r_addr, r_wdata;
  logic        r_we;
  logic [3:0]  r_be;
  logic [2:0]  r_prot;
  logic [1:0]  r_memtype;

  assign w_full   = (r_cnt == CNT_W'(MAX_OUTSTANDING));
  assign w_accept = trans_valid_i && trans_ready_o;

  always_comb begin
    w_state_n     = r_state;
    w_latch       = 1'b0;
    trans_ready_o = 1'b0;
    obi_req_o     = 1'b0;
    obi_addr_o    = trans_addr_i;
    obi_we_o      = trans_we_i;
    obi_be_o      = trans_be_i;
    obi_wdata_o   = trans_wdata_i;
    obi_prot_o    = trans_prot_i;
    obi_memtype_o = trans_memtype_i;
    unique case (r_state)
      StTransparent: begin
        trans_ready_o = !w_full;
        obi_req_o     = trans_valid_i && !w_full;
        if (trans_valid_i && !w_full && !obi_gnt_i) begin
          w_latch   = 1'b1;
          w_state_n = StRegistered;
        end
      end
      StRegistered: begin
        obi_req_o     = 1'b1;
        obi_addr_o    = r_addr;
        obi_we_o      = r_we;
        obi_be_o      = r_be;
        obi_wdata_o   = r_wdata;
        obi_prot_o    = r_prot;
        obi_memtype_o = r_memtype;
        if (obi_gnt_i) begin
          w_state_n = StTransparent;
        end
      end
    endcase
  end

  // A response with nothing outstanding is a bus violation; the count saturates at zero.
  always_comb begin
    w_cnt_n = r_cnt;
    if (w_accept && !obi_rvalid_i) begin
      w_cnt_n = r_cnt + CNT_W'(1);
    end else if (!w_accept && obi_rvalid_i && (r_cnt != '0)) begin
      w_cnt_n = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StTransparent;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_prot    <= '0;
      r_memtype <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_latch) begin
        r_addr    <= trans_addr_i;
        r_we      <= trans_we_i;
        r_be      <= trans_be_i;
        r_wdata   <= trans_wdata_i;
        r_prot    <= trans_prot_i;
        r_memtype <= trans_memtype_i;
      end
    end
  end

  assign one_txn_pend_n_o  = (w_cnt_n == CNT_W'(1));
  assign outstanding_cnt_o = r_cnt;
  assign resp_valid_o      = obi_rvalid_i;
  assign resp_rdata_o      = obi_rdata_i;
  assign resp_err_o        = obi_err_i && obi_rvalid_i;

`ifndef SYNTHESIS
  rvalid_with_none_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) !(obi_rvalid_i && (r_cnt == '0)));
`endif

endmodule

// File: tb/tb_cv32e40s_obi_txn_tracker.sv
// Bench for cv32e40s_obi_txn_tracker: directed scenarios plus randomized traffic checked
// against a transaction-level model (in-flight count, held address phase).
module tb_cv32e40s_obi_txn_tracker;
  localparam int unsigned MAXO = 2;
  localparam int unsigned CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trans_valid_i, trans_ready_o;
  logic [31:0]   trans_addr_i, trans_wdata_i;
  logic          trans_we_i;
  logic [3:0]    trans_be_i;
  logic [2:0]    trans_prot_i;
  logic [1:0]    trans_memtype_i;
  logic          obi_req_o, obi_gnt_i;
  logic [31:0]   obi_addr_o, obi_wdata_o;
  logic          obi_we_o;
  logic [3:0]    obi_be_o;
  logic [2:0]    obi_prot_o;
  logic [1:0]    obi_memtype_o;
  logic          obi_rvalid_i, obi_err_i;
  logic [31:0]   obi_rdata_i;
  logic          resp_valid_o, resp_err_o;
  logic [31:0]   resp_rdata_o;
  logic [CW-1:0] outstanding_cnt_o;
  logic          one_txn_pend_n_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cv32e40s_obi_txn_tracker #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
    .trans_addr_i(trans_addr_i), .trans_we_i(trans_we_i), .trans_be_i(trans_be_i),
    .trans_wdata_i(trans_wdata_i), .trans_prot_i(trans_prot_i),
    .trans_memtype_i(trans_memtype_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i),
    .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
    .obi_wdata_o(obi_wdata_o), .obi_prot_o(obi_prot_o), .obi_memtype_o(obi_memtype_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .outstanding_cnt_o(outstanding_cnt_o), .one_txn_pend_n_o(one_txn_pend_n_o)
  );

  task automatic idle();
    trans_valid_i   = 1'b0;
    trans_addr_i    = '0;
    trans_we_i      = 1'b0;
    trans_be_i      = '0;
    trans_wdata_i   = '0;
    trans_prot_i    = '0;
    trans_memtype_i = '0;
    obi_gnt_i       = 1'b0;
    obi_rvalid_i    = 1'b0;
    obi_rdata_i     = '0;
    obi_err_i       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    n_checks++;
    if ({outstanding_cnt_o, trans_ready_o, obi_req_o, one_txn_pend_n_o} !== {CW'(0), 3'b100}) begin
      n_errors++;
      $display("FAIL reset_idle: got cnt=%0d rdy=%b req=%b pend=%b, expected 0 1 0 0",
               outstanding_cnt_o, trans_ready_o, obi_req_o, one_txn_pend_n_o);
    end
    trans_valid_i = 1'b1;
    obi_rvalid_i  = 1'b1;
    #1;
    n_checks++;
    if ({obi_req_o, resp_valid_o} !== 2'b11) begin
      n_errors++;
      $display("FAIL reset_passthru: got req=%b rvalid=%b, expected 1 1", obi_req_o, resp_valid_o);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (outstanding_cnt_o !== CW'(0)) begin
      n_errors++;
      $display("FAIL reset_hold_cnt: got %0d expected 0", outstanding_cnt_o);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk); idle();
    trans_valid_i = 1'b1; trans_addr_i = 32'h1000_0040; obi_gnt_i = 1'b1;
    #1;
    n_checks++;
    if ({trans_ready_o, obi_req_o, one_txn_pend_n_o, outstanding_cnt_o} !== {3'b111, CW'(0)}) begin
      n_errors++;
      $display("FAIL read_accept: got rdy=%b req=%b pend=%b cnt=%0d, expected 1 1 1 0",
               trans_ready_o, obi_req_o, one_txn_pend_n_o, outstanding_cnt_o);
    end
    @(negedge clk); idle();
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if ({outstanding_cnt_o, resp_valid_o, resp_rdata_o, one_txn_pend_n_o}
        !== {CW'(1), 1'b1, 32'hCAFE_F00D, 1'b0}) begin
      n_errors++;
      $display("FAIL read_resp: got cnt=%0d v=%b data=%h pend=%b, expected 1 1 cafef00d 0",
               outstanding_cnt_o, resp_valid_o, resp_rdata_o, one_txn_pend_n_o);
    end
    @(negedge clk); idle();
    #1;
    n_checks++;
    if (outstanding_cnt_o !== CW'(0)) begin
      n_errors++;
      $display("FAIL read_drain: got cnt=%0d expected 0", outstanding_cnt_o);
    end
  endtask

  task automatic test_stall_write();
    logic [31:0] wd;
    wd = $urandom;
    @(negedge clk); idle();
    trans_valid_i = 1'b1; trans_addr_i = 32'h2000_0010; trans_we_i = 1'b1;
    trans_be_i = 4'hF; trans_wdata_i = wd; trans_prot_i = 3'b011; trans_memtype_i = 2'b01;
    #1;
    n_checks++;
    if ({obi_req_o, trans_ready_o, obi_addr_o} !== {2'b11, 32'h2000_0010}) begin
      n_errors++;
      $display("FAIL stall_first: got req=%b rdy=%b addr=%h", obi_req_o, trans_ready_o, obi_addr_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      trans_addr_i = 32'h0; trans_we_i = 1'b0; trans_wdata_i = ~wd; trans_be_i = 4'h0;
      trans_prot_i = 3'b000; trans_memtype_i = 2'b10;
      #1;
      n_checks++;
      if ({trans_ready_o, obi_req_o, obi_addr_o, obi_we_o, obi_wdata_o, obi_be_o, obi_prot_o,
           obi_memtype_o} !== {2'b01, 32'h2000_0010, 1'b1, wd, 4'hF, 3'b011, 2'b01}) begin
        n_errors++;
        $display("FAIL stall_hold%0d: got rdy=%b req=%b addr=%h we=%b wd=%h be=%h, expected 0 1 20000010 1 %h f",
                 i, trans_ready_o, obi_req_o, obi_addr_o, obi_we_o, obi_wdata_o, obi_be_o, wd);
      end
    end
    @(negedge clk);
    obi_gnt_i = 1'b1;
    #1;
    n_checks++;
    if ({obi_req_o, trans_ready_o, obi_addr_o, outstanding_cnt_o}
        !== {2'b10, 32'h2000_0010, CW'(1)}) begin
      n_errors++;
      $display("FAIL stall_gnt: got req=%b rdy=%b addr=%h cnt=%0d",
               obi_req_o, trans_ready_o, obi_addr_o, outstanding_cnt_o);
    end
    @(negedge clk); idle();
    trans_addr_i = 32'h3333_0000;
    #1;
    n_checks++;
    if ({trans_ready_o, obi_req_o, obi_addr_o, outstanding_cnt_o}
        !== {2'b10, 32'h3333_0000, CW'(1)}) begin
      n_errors++;
      $display("FAIL stall_release: got rdy=%b req=%b addr=%h cnt=%0d, expected 1 0 33330000 1",
               trans_ready_o, obi_req_o, obi_addr_o, outstanding_cnt_o);
    end
    @(negedge clk); idle(); obi_rvalid_i = 1'b1;
    @(negedge clk); idle();
    #1;
    n_checks++;
    if (outstanding_cnt_o !== CW'(0)) begin
      n_errors++;
      $display("FAIL stall_drain: got cnt=%0d expected 0", outstanding_cnt_o);
    end
  endtask

  task automatic test_full_and_overlap();
    @(negedge clk); idle();
    trans_valid_i = 1'b1; obi_gnt_i = 1'b1; trans_addr_i = 32'h100;
    @(negedge clk); trans_addr_i = 32'h104;
    #1;
    n_checks++;
    if ({outstanding_cnt_o, trans_ready_o} !== {CW'(1), 1'b1}) begin
      n_errors++;
      $display("FAIL full_second: got cnt=%0d rdy=%b, expected 1 1", outstanding_cnt_o, trans_ready_o);
    end
    @(negedge clk); trans_addr_i = 32'h108;
    #1;
    n_checks++;
    if ({outstanding_cnt_o, trans_ready_o, obi_req_o} !== {CW'(2), 2'b00}) begin
      n_errors++;
      $display("FAIL full_block: got cnt=%0d rdy=%b req=%b, expected 2 0 0",
               outstanding_cnt_o, trans_ready_o, obi_req_o);
    end
    @(negedge clk); obi_rvalid_i = 1'b1;
    #1;
    n_checks++;
    if ({trans_ready_o, obi_req_o, one_txn_pend_n_o} !== 3'b001) begin
      n_errors++;
      $display("FAIL full_no_bypass: got rdy=%b req=%b pend=%b, expected 0 0 1",
               trans_ready_o, obi_req_o, one_txn_pend_n_o);
    end
    @(negedge clk); idle();
    #1;
    n_checks++;
    if ({outstanding_cnt_o, trans_ready_o} !== {CW'(1), 1'b1}) begin
      n_errors++;
      $display("FAIL full_reopen: got cnt=%0d rdy=%b, expected 1 1", outstanding_cnt_o, trans_ready_o);
    end
    @(negedge clk);
    trans_valid_i = 1'b1; obi_gnt_i = 1'b1; obi_rvalid_i = 1'b1;
    #1;
    n_checks++;
    if ({trans_ready_o, one_txn_pend_n_o} !== 2'b11) begin
      n_errors++;
      $display("FAIL overlap_pend: got rdy=%b pend=%b, expected 1 1", trans_ready_o, one_txn_pend_n_o);
    end
    @(negedge clk); idle();
    #1;
    n_checks++;
    if (outstanding_cnt_o !== CW'(1)) begin
      n_errors++;
      $display("FAIL overlap_cnt: got cnt=%0d expected 1", outstanding_cnt_o);
    end
    obi_rvalid_i = 1'b1;
    @(negedge clk); idle();
  endtask

  task automatic test_err();
    @(negedge clk); idle(); trans_valid_i = 1'b1; obi_gnt_i = 1'b1;
    @(negedge clk); idle(); obi_rvalid_i = 1'b1; obi_err_i = 1'b1;
    #1;
    n_checks++;
    if ({resp_valid_o, resp_err_o} !== 2'b11) begin
      n_errors++;
      $display("FAIL err_with_rvalid: got v=%b err=%b, expected 1 1", resp_valid_o, resp_err_o);
    end
    @(negedge clk); idle(); obi_err_i = 1'b1;
    #1;
    n_checks++;
    if ({resp_valid_o, resp_err_o, outstanding_cnt_o} !== {2'b00, CW'(0)}) begin
      n_errors++;
      $display("FAIL err_no_rvalid: got v=%b err=%b cnt=%0d, expected 0 0 0",
               resp_valid_o, resp_err_o, outstanding_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle(); trans_valid_i = 1'b1; obi_gnt_i = 1'b1; trans_addr_i = 32'h400;
    @(negedge clk); obi_gnt_i = 1'b0; trans_addr_i = 32'hABCD_0000;
    @(negedge clk); idle(); trans_addr_i = 32'h5555_0000;
    #1;
    n_checks++;
    if ({outstanding_cnt_o, trans_ready_o, obi_req_o, obi_addr_o}
        !== {CW'(2), 2'b01, 32'hABCD_0000}) begin
      n_errors++;
      $display("FAIL midrst_pre: got cnt=%0d rdy=%b req=%b addr=%h, expected 2 0 1 abcd0000",
               outstanding_cnt_o, trans_ready_o, obi_req_o, obi_addr_o);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({outstanding_cnt_o, trans_ready_o, obi_req_o, obi_addr_o}
        !== {CW'(0), 2'b10, 32'h5555_0000}) begin
      n_errors++;
      $display("FAIL midrst_async: got cnt=%0d rdy=%b req=%b addr=%h, expected 0 1 0 55550000",
               outstanding_cnt_o, trans_ready_o, obi_req_o, obi_addr_o);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random();
    int          m_cnt = 0;
    bit          m_hold = 1'b0;
    logic [73:0] m_attr = '0;
    logic [73:0] in_attr, exp_attr;
    bit          exp_req, exp_ready, acc;
    int          nxt;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      trans_valid_i   = ($urandom_range(0, 3) != 0);
      trans_addr_i    = $urandom;
      trans_we_i      = 1'($urandom_range(0, 1));
      trans_be_i      = 4'($urandom);
      trans_wdata_i   = $urandom;
      trans_prot_i    = 3'($urandom);
      trans_memtype_i = 2'($urandom);
      obi_gnt_i       = 1'($urandom_range(0, 1));
      // Responses only for transactions granted in an earlier cycle.
      obi_rvalid_i    = ((m_cnt - int'(m_hold)) > 0) && ($urandom_range(0, 2) == 0);
      obi_rdata_i     = $urandom;
      obi_err_i       = 1'($urandom_range(0, 1));
      in_attr = {trans_addr_i, trans_we_i, trans_be_i, trans_wdata_i, trans_prot_i,
                 trans_memtype_i};
      if (m_hold) begin
        exp_req = 1'b1; exp_ready = 1'b0; exp_attr = m_attr;
      end else begin
        exp_ready = (m_cnt < int'(MAXO));
        exp_req   = trans_valid_i && exp_ready;
        exp_attr  = in_attr;
      end
      acc = trans_valid_i && exp_ready;
      nxt = m_cnt + int'(acc) - int'(obi_rvalid_i);
      if (nxt < 0) nxt = 0;
      #1;
      n_checks++;
      if ({obi_req_o, trans_ready_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_prot_o,
           obi_memtype_o} !== {exp_req, exp_ready, exp_attr}) begin
        n_errors++;
        $display("FAIL rand_addr_phase[%0d]: got req=%b rdy=%b addr=%h, expected %b %b %h",
                 i, obi_req_o, trans_ready_o, obi_addr_o, exp_req, exp_ready, exp_attr[73:42]);
      end
      n_checks++;
      if ({outstanding_cnt_o, one_txn_pend_n_o} !== {CW'(m_cnt), (nxt == 1)}) begin
        n_errors++;
        $display("FAIL rand_count[%0d]: got cnt=%0d pend=%b, expected %0d %b",
                 i, outstanding_cnt_o, one_txn_pend_n_o, m_cnt, (nxt == 1));
      end
      n_checks++;
      if ({resp_valid_o, resp_rdata_o, resp_err_o}
          !== {obi_rvalid_i, obi_rdata_i, obi_err_i & obi_rvalid_i}) begin
        n_errors++;
        $display("FAIL rand_resp[%0d]: got v=%b d=%h e=%b", i, resp_valid_o, resp_rdata_o,
                 resp_err_o);
      end
      if (m_hold) begin
        if (obi_gnt_i) m_hold = 1'b0;
      end else if (acc && !obi_gnt_i) begin
        m_hold = 1'b1;
        m_attr = in_attr;
      end
      m_cnt = nxt;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_stall_write();
    test_full_and_overlap();
    test_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
